// File: rtl/adc_frame_sequencer_pkg.sv
// adc_frame_sequencer_pkg
//   Shared types and constants for the ADC frame sequencer.
//   - state_t  : frame sequencer FSM states
//   - MAX_CH   : largest channel count a frame may read
//   - CH_W     : width of the channel index / sample_ch output
//   - max_u    : unsigned maximum, used when sizing the shared cycle counter
package adc_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVST,
    S_WAIT_HI,
    S_WAIT_LO,
    S_RD_LOW,
    S_RD_HIGH,
    S_DONE
  } state_t;

  localparam int unsigned MAX_CH = 8;
  localparam int unsigned CH_W   = $clog2(MAX_CH);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_frame_sequencer_if.sv
// adc_frame_sequencer_if
//   Parallel-output ADC pin bundle.
//   adc_convst  conversion start, active-high   (sequencer -> ADC)
//   adc_cs_n    chip select, active-low         (sequencer -> ADC)
//   adc_rd_n    read strobe, active-low         (sequencer -> ADC)
//   adc_busy    conversion in progress, async   (ADC -> sequencer)
//   adc_db      conversion result bus           (ADC -> sequencer)
//   modport master : the sequencer side
//   modport slave  : the ADC (or ADC model) side
interface adc_frame_sequencer_if #(
  parameter int unsigned DATA_W = 16
);

  logic              adc_convst;
  logic              adc_cs_n;
  logic              adc_rd_n;
  logic              adc_busy;
  logic [DATA_W-1:0] adc_db;

  modport master (
    output adc_convst,
    output adc_cs_n,
    output adc_rd_n,
    input  adc_busy,
    input  adc_db
  );

  modport slave (
    input  adc_convst,
    input  adc_cs_n,
    input  adc_rd_n,
    output adc_busy,
    output adc_db
  );

endinterface

// File: rtl/adc_frame_sequencer_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for slow, level-type signals crossing into clk.
//   Parameters: WIDTH (bits, each synchronized independently),
//               RESET_VAL (value both stages take in reset).
//   Ports: clk, rst (async, active-high), i_d (async input), o_q (synced).
module sync_2ff #(
  parameter int unsigned WIDTH     = 1,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= {WIDTH{RESET_VAL}};
      r_sync <= {WIDTH{RESET_VAL}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer
//   Runs one conversion frame of the external parallel ADC per trigger:
//   CONVST pulse, BUSY rise/fall handshake (with timeout), then NUM_CH
//   CS/RD read strobes, each word presented with a 1-cycle sample_valid.
//
//   Ports:
//     clk, rst      clock; asynchronous active-high reset
//     enable        gates new triggers; an in-flight frame always completes
//     trigger       1-cycle frame start pulse
//     clr_err       clears the sticky error flags (a coincident set wins)
//     adc           ADC pin bundle (master modport)
//     sample_data   captured ADC word
//     sample_ch     channel index of sample_data
//     sample_valid  1-cycle strobe per channel
//     frame_done    1-cycle strobe when the frame completes
//     busy          high whenever the sequencer is not idle
//     err_timeout   sticky: a BUSY wait exceeded TIMEOUT_CYC cycles
//     err_overrun   sticky: trigger arrived while a frame was in progress
module adc_frame_sequencer
  import adc_frame_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CONVST_CYC  = 4,
  parameter int unsigned RD_LOW_CYC  = 3,
  parameter int unsigned RD_HIGH_CYC = 2,
  parameter int unsigned TIMEOUT_CYC = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  trigger,
  input  logic                  clr_err,
  adc_frame_sequencer_if.master adc,
  output logic [DATA_W-1:0]     sample_data,
  output logic [CH_W-1:0]       sample_ch,
  output logic                  sample_valid,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_overrun
);

  localparam int unsigned CNT_MAX = max_u(max_u(TIMEOUT_CYC, CONVST_CYC),
                                          max_u(RD_LOW_CYC, RD_HIGH_CYC));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter reload values: a state lasting N cycles is entered with N-1 and
  // exits in the cycle the counter reads zero.
  localparam cnt_t LD_CONVST  = cnt_t'(CONVST_CYC - 1);
  localparam cnt_t LD_TIMEOUT = cnt_t'(TIMEOUT_CYC - 1);
  localparam cnt_t LD_RD_LOW  = cnt_t'(RD_LOW_CYC - 1);
  localparam cnt_t LD_RD_HIGH = cnt_t'(RD_HIGH_CYC - 1);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t            r_state;
  state_t            w_next;
  cnt_t              r_cnt;
  cnt_t              w_cnt_next;
  logic [CH_W-1:0]   r_idx;
  logic [CH_W-1:0]   w_idx_next;

  logic              w_busy_s;
  logic              w_timeout;
  logic              w_capture;
  logic              w_overrun;

  logic              r_convst;
  logic              r_cs_n;
  logic              r_rd_n;
  logic [DATA_W-1:0] r_sample_data;
  logic [CH_W-1:0]   r_sample_ch;
  logic              r_sample_valid;
  logic              r_frame_done;
  logic              r_busy;
  logic              r_err_timeout;
  logic              r_err_overrun;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_busy_sync (
    .clk (clk),
    .rst (rst),
    .i_d (adc.adc_busy),
    .o_q (w_busy_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = (r_cnt != '0) ? (r_cnt - cnt_t'(1)) : r_cnt;
    w_idx_next = r_idx;
    w_timeout  = 1'b0;
    w_capture  = 1'b0;
    w_overrun  = trigger && (r_state != S_IDLE);

    unique case (r_state)
      S_IDLE: begin
        if (trigger && enable) begin
          w_next     = S_CONVST;
          w_cnt_next = LD_CONVST;
          w_idx_next = '0;
        end
      end

      S_CONVST: begin
        if (r_cnt == '0) begin
          w_next     = S_WAIT_HI;
          w_cnt_next = LD_TIMEOUT;
        end
      end

      S_WAIT_HI: begin
        if (w_busy_s) begin
          w_next     = S_WAIT_LO;
          w_cnt_next = LD_TIMEOUT;
        end else if (r_cnt == '0) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end

      S_WAIT_LO: begin
        if (!w_busy_s) begin
          w_next     = S_RD_LOW;
          w_cnt_next = LD_RD_LOW;
        end else if (r_cnt == '0) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end

      S_RD_LOW: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          if (r_idx == LAST_CH) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_RD_HIGH;
            w_cnt_next = LD_RD_HIGH;
          end
        end
      end

      S_RD_HIGH: begin
        if (r_cnt == '0) begin
          w_next     = S_RD_LOW;
          w_cnt_next = LD_RD_LOW;
          w_idx_next = r_idx + CH_W'(1);
        end
      end

      S_DONE: begin
        w_next = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Pin and status outputs are decoded from the next state and registered,
  // so each output is valid in exactly the cycles its state occupies and
  // no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_convst       <= 1'b0;
      r_cs_n         <= 1'b1;
      r_rd_n         <= 1'b1;
      r_sample_data  <= '0;
      r_sample_ch    <= '0;
      r_sample_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_busy         <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_overrun  <= 1'b0;
    end else begin
      r_convst       <= (w_next == S_CONVST);
      r_cs_n         <= !((w_next == S_RD_LOW) || (w_next == S_RD_HIGH));
      r_rd_n         <= (w_next != S_RD_LOW);
      r_frame_done   <= (w_next == S_DONE);
      r_busy         <= (w_next != S_IDLE);
      r_sample_valid <= w_capture;

      if (w_capture) begin
        r_sample_data <= adc.adc_db;
        r_sample_ch   <= r_idx;
      end

      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end else if (clr_err) begin
        r_err_timeout <= 1'b0;
      end

      if (w_overrun) begin
        r_err_overrun <= 1'b1;
      end else if (clr_err) begin
        r_err_overrun <= 1'b0;
      end
    end
  end

  assign adc.adc_convst = r_convst;
  assign adc.adc_cs_n   = r_cs_n;
  assign adc.adc_rd_n   = r_rd_n;

  assign sample_data  = r_sample_data;
  assign sample_ch    = r_sample_ch;
  assign sample_valid = r_sample_valid;
  assign frame_done   = r_frame_done;
  assign busy         = r_busy;
  assign err_timeout  = r_err_timeout;
  assign err_overrun  = r_err_overrun;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb_adc_frame_sequencer
//   Self-checking bench for adc_frame_sequencer. A behavioural ADC drives
//   BUSY/DB in reaction to CONVST/RD; a monitor records strobes and pin
//   pulse widths; expectations come from the frame rules (word k on
//   channel k, pulse widths, frame length after BUSY falls, timeouts).
module tb_adc_frame_sequencer;
  import adc_frame_sequencer_pkg::*;

  localparam int NCH       = 3;
  localparam int DW        = 16;
  localparam int CCYC      = 4;
  localparam int RLC       = 3;
  localparam int RHC       = 2;
  localparam int TOC       = 512;
  localparam int FRAME_LEN = NCH * RLC + (NCH - 1) * RHC + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            trigger;
  logic            clr_err;
  logic [DW-1:0]   sample_data;
  logic [CH_W-1:0] sample_ch;
  logic            sample_valid;
  logic            frame_done;
  logic            busy;
  logic            err_timeout;
  logic            err_overrun;

  adc_frame_sequencer_if #(.DATA_W(DW)) u_if ();

  adc_frame_sequencer #(
    .NUM_CH      (NCH),
    .DATA_W      (DW),
    .CONVST_CYC  (CCYC),
    .RD_LOW_CYC  (RLC),
    .RD_HIGH_CYC (RHC),
    .TIMEOUT_CYC (TOC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .trigger      (trigger),
    .clr_err      (clr_err),
    .adc          (u_if.master),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .frame_done   (frame_done),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  function automatic void chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endfunction

  // ---------------- ADC model ----------------
  int          mdl_mode;   // 0: normal, 1: BUSY never rises, 2: BUSY stuck high
  int          mdl_dly;
  int          mdl_blen;
  int          dly_cnt;
  int          blen_cnt;
  int          rd_cnt;
  int          busy_rise_adc;
  int          busy_fall_adc;
  logic        prev_convst;
  logic        prev_rd;
  logic [15:0] mw [NCH];

  task automatic adc_step();
    if (prev_convst && !u_if.adc_convst && mdl_mode != 1) begin
      dly_cnt = mdl_dly;
    end else if (dly_cnt > 0) begin
      dly_cnt--;
      if (dly_cnt == 0) begin
        u_if.adc_busy = 1'b1;
        busy_rise_adc = cyc;
        blen_cnt      = mdl_blen;
      end
    end else if (mdl_mode == 0 && blen_cnt > 0) begin
      blen_cnt--;
      if (blen_cnt == 0) begin
        u_if.adc_busy = 1'b0;
        busy_fall_adc = cyc;
      end
    end
    if (prev_rd && !u_if.adc_rd_n) begin
      u_if.adc_db = (rd_cnt < NCH) ? mw[rd_cnt] : 16'hDEAD;
      rd_cnt++;
    end
    prev_convst = u_if.adc_convst;
    prev_rd     = u_if.adc_rd_n;
  endtask

  task automatic release_model();
    u_if.adc_busy = 1'b0;
    dly_cnt       = 0;
    blen_cnt      = 0;
  endtask

  // ---------------- monitor ----------------
  int          vq_ch [$];
  logic [15:0] vq_data [$];
  int          rdq [$];
  int          cvq [$];
  int          cv_start;
  int          fd_cnt;
  int          fd_cyc;
  int          busy_fall_dut;
  int          trig_cyc;
  int          rd_run;
  int          cv_run;
  logic        prev_busy;

  task automatic mon_step();
    if (sample_valid) begin
      vq_ch.push_back(int'(sample_ch));
      vq_data.push_back(sample_data);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (!u_if.adc_rd_n) rd_run++;
    else if (rd_run > 0) begin
      rdq.push_back(rd_run);
      rd_run = 0;
    end
    if (u_if.adc_convst) begin
      if (cv_run == 0) cv_start = cyc;
      cv_run++;
    end else if (cv_run > 0) begin
      cvq.push_back(cv_run);
      cv_run = 0;
    end
    if (prev_busy && !busy) busy_fall_dut = cyc;
    prev_busy = busy;
  endtask

  task automatic clear_mon();
    vq_ch.delete();
    vq_data.delete();
    rdq.delete();
    cvq.delete();
    fd_cnt        = 0;
    fd_cyc        = -1;
    cv_start      = -1;
    rd_run        = 0;
    cv_run        = 0;
    busy_fall_dut = -1;
    busy_fall_adc = -1;
    busy_rise_adc = -100000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mon_step();
    adc_step();
  endtask

  // ---------------- frame helpers ----------------
  task automatic start_frame(input int mode, input int dly, input int blen);
    clear_mon();
    mdl_mode = mode;
    mdl_dly  = dly;
    mdl_blen = blen;
    rd_cnt   = 0;
    dly_cnt  = 0;
    blen_cnt = 0;
    trigger  = 1'b1;
    trig_cyc = cyc;
    tick();
    trigger  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    bit seen;
    n    = 0;
    seen = busy;
    while (n < bound && !(seen && !busy)) begin
      tick();
      if (busy) seen = 1'b1;
      n++;
    end
    chk({tag, " idle_within_bound"}, (n < bound), 1);
  endtask

  task automatic clr_pulse(input string tag);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk({tag, " clr_err_timeout"}, err_timeout, 0);
    chk({tag, " clr_err_overrun"}, err_overrun, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " convst"},       u_if.adc_convst, 0);
    chk({tag, " cs_n"},         u_if.adc_cs_n,   1);
    chk({tag, " rd_n"},         u_if.adc_rd_n,   1);
    chk({tag, " sample_data"},  sample_data,     0);
    chk({tag, " sample_ch"},    sample_ch,       0);
    chk({tag, " sample_valid"}, sample_valid,    0);
    chk({tag, " frame_done"},   frame_done,      0);
    chk({tag, " busy"},         busy,            0);
    chk({tag, " err_timeout"},  err_timeout,     0);
    chk({tag, " err_overrun"},  err_overrun,     0);
  endtask

  task automatic check_frame(input string tag, input int exp_n, input bit exp_to,
                             input bit exp_ov, input bit exp_cv, input int mode);
    chk({tag, " n_samples"}, vq_ch.size(), exp_n);
    for (int k = 0; k < vq_ch.size() && k < exp_n; k++) begin
      chk($sformatf("%s ch[%0d]", tag, k),   vq_ch[k],   k);
      chk($sformatf("%s data[%0d]", tag, k), vq_data[k], mw[k]);
    end
    chk({tag, " frame_done_count"}, fd_cnt, (exp_n == NCH) ? 1 : 0);
    if (exp_n == NCH) begin
      chk_rng({tag, " frame_len_after_busy_fall"}, fd_cyc - busy_fall_adc,
              FRAME_LEN + 2, FRAME_LEN + 3);
      chk({tag, " busy_drop_after_done"}, busy_fall_dut, fd_cyc + 1);
    end
    chk({tag, " rd_pulses"}, rdq.size(), exp_n);
    foreach (rdq[k]) chk($sformatf("%s rd_low_width[%0d]", tag, k), rdq[k], RLC);
    chk({tag, " convst_pulses"}, cvq.size(), exp_cv ? 1 : 0);
    if (exp_cv && cvq.size() > 0) begin
      chk({tag, " convst_start"}, cv_start, trig_cyc + 1);
      chk({tag, " convst_width"}, cvq[0], CCYC);
    end
    if (exp_to && mode == 1)
      chk({tag, " wait_hi_timeout_cycle"}, busy_fall_dut, trig_cyc + CCYC + TOC + 1);
    if (exp_to && mode == 2)
      chk_rng({tag, " wait_lo_timeout_cycle"}, busy_fall_dut - busy_rise_adc, TOC + 3, TOC + 4);
    chk({tag, " err_timeout"}, err_timeout, exp_to);
    chk({tag, " err_overrun"}, err_overrun, exp_ov);
    chk({tag, " busy_end"},    busy,        0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int               mode;
    bit               en;
    logic [2:0][15:0] w;
    int               exp_n;
    bit               exp_to;
    bit               exp_cv;
  } vec_t;

  function automatic vec_t mkvec(input int mode, input bit en, input logic [15:0] w0,
                                 input logic [15:0] w1, input logic [15:0] w2,
                                 input int exp_n, input bit exp_to, input bit exp_cv);
    vec_t v;
    v.mode   = mode;
    v.en     = en;
    v.w[0]   = w0;
    v.w[1]   = w1;
    v.w[2]   = w2;
    v.exp_n  = exp_n;
    v.exp_to = exp_to;
    v.exp_cv = exp_cv;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    clr_pulse(tag);
    enable = v.en;
    for (int k = 0; k < NCH; k++) mw[k] = v.w[k];
    start_frame(v.mode, 3, 100);
    if (v.exp_cv) wait_idle(tag, 2000);
    else repeat (12) tick();
    release_model();
    repeat (4) tick();
    check_frame(tag, v.exp_n, v.exp_to, 1'b0, v.exp_cv, v.mode);
    enable = 1'b1;
  endtask

  task automatic reset_mid(input int which, input string tag);
    int n;
    clr_pulse(tag);
    mw[0] = 16'h0A0A; mw[1] = 16'h0B0B; mw[2] = 16'h0C0C;
    start_frame(0, 3, 100);
    n = 0;
    while (n < 600 && !((which == 0) ? (u_if.adc_busy && busy && (cyc - busy_rise_adc) >= 5)
                                     : (rd_cnt >= 1 && u_if.adc_rd_n && !u_if.adc_cs_n))) begin
      tick();
      n++;
    end
    chk({tag, " reached_state"}, (n < 600), 1);
    #3;
    rst = 1'b1;
    #1;
    chk_reset({tag, " async"});
    release_model();
    repeat (3) tick();
    chk({tag, " no_frame_done"}, fd_cnt, 0);
    chk({tag, " busy_in_reset"}, busy, 0);
    rst = 1'b0;
    tick();
    run_vec(mkvec(0, 1'b1, 16'h1234, 16'h5678, 16'h9ABC, NCH, 1'b0, 1'b1), {tag, " clean"});
  endtask

  // ---------------- stimulus ----------------
  vec_t vt [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    enable        = 1'b1;
    trigger       = 1'b0;
    clr_err       = 1'b0;
    u_if.adc_busy = 1'b0;
    u_if.adc_db   = '0;
    prev_convst   = 1'b0;
    prev_rd       = 1'b1;
    prev_busy     = 1'b0;
    mdl_mode      = 0;
    mdl_dly       = 3;
    mdl_blen      = 100;
    dly_cnt       = 0;
    blen_cnt      = 0;
    rd_cnt        = 0;
    for (int k = 0; k < NCH; k++) mw[k] = '0;
    clear_mon();

    vt[0] = mkvec(0, 1'b1, 16'h1111, 16'h2222, 16'h3333, NCH, 1'b0, 1'b1);
    vt[1] = mkvec(1, 1'b1, 16'h1111, 16'h2222, 16'h3333, 0,   1'b1, 1'b1);
    vt[2] = mkvec(0, 1'b1, 16'hFFFF, 16'h0000, 16'hA5A5, NCH, 1'b0, 1'b1);
    vt[3] = mkvec(0, 1'b0, 16'h4444, 16'h5555, 16'h6666, 0,   1'b0, 1'b0);
    vt[4] = mkvec(2, 1'b1, 16'h7777, 16'h8888, 16'h9999, 0,   1'b1, 1'b1);
    vt[5] = mkvec(0, 1'b1, 16'h8000, 16'h0001, 16'h7FFE, NCH, 1'b0, 1'b1);

    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Overrun: trigger while channel 1 is being read.
    begin
      int n;
      clr_pulse("overrun");
      mw[0] = 16'h1111; mw[1] = 16'h2222; mw[2] = 16'h3333;
      start_frame(0, 3, 100);
      n = 0;
      while (n < 400 && rd_cnt < 2) begin
        tick();
        n++;
      end
      chk("overrun reached_ch1", (n < 400), 1);
      chk("overrun rd_n_low_at_trigger", u_if.adc_rd_n, 0);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      chk("overrun flag_set", err_overrun, 1);
      wait_idle("overrun", 2000);
      repeat (4) tick();
      check_frame("overrun", NCH, 1'b0, 1'b1, 1'b1, 0);
    end

    // enable dropped right after the frame starts: frame still completes.
    clr_pulse("en_drop");
    mw[0] = 16'hC001; mw[1] = 16'hC002; mw[2] = 16'hC003;
    start_frame(0, 5, 40);
    enable = 1'b0;
    wait_idle("en_drop", 2000);
    enable = 1'b1;
    repeat (4) tick();
    check_frame("en_drop", NCH, 1'b0, 1'b0, 1'b1, 0);

    // clr_err held while a WAIT_LO timeout fires: the set wins, then clears.
    clr_err = 1'b1;
    start_frame(2, 3, 100);
    wait_idle("clr_vs_set", 2000);
    chk("clr_vs_set err_timeout_set", err_timeout, 1);
    tick();
    chk("clr_vs_set err_timeout_cleared", err_timeout, 0);
    clr_err = 1'b0;
    release_model();
    repeat (4) tick();

    // Back-to-back: second trigger in the first idle cycle.
    clr_pulse("b2b");
    mw[0] = 16'h0101; mw[1] = 16'h0202; mw[2] = 16'h0303;
    start_frame(0, 2, 20);
    wait_idle("b2b first", 2000);
    chk("b2b first frame_done", fd_cnt, 1);
    mw[0] = 16'h0404; mw[1] = 16'h0505; mw[2] = 16'h0606;
    start_frame(0, 2, 20);
    wait_idle("b2b second", 2000);
    repeat (4) tick();
    check_frame("b2b second", NCH, 1'b0, 1'b0, 1'b1, 0);

    reset_mid(0, "rst_wait_lo");
    reset_mid(1, "rst_rd_high");

    // Randomised frames: random words and BUSY timing.
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("rand%0d", i);
      for (int k = 0; k < NCH; k++) mw[k] = 16'($urandom);
      start_frame(0, int'($urandom_range(1, 8)), int'($urandom_range(3, 150)));
      wait_idle(tag, 2000);
      repeat (4) tick();
      check_frame(tag, NCH, 1'b0, 1'b0, 1'b1, 0);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
